// File: rtl/gpr_file.sv
// rtl/gpr_file.sv - write-back register file with two ID read ports and a debug read port
// Optional same-cycle write-through on the ID ports: define GPR_WB_BYPASS_EN.
module gpr_file #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] SP_INIT    = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_GPR_we,
    input  logic [ADDR_WIDTH-1:0] wb_GPR_waddr,
    input  logic [1:0]            wb_GPR_wdata_select,
    input  logic [DATA_WIDTH-1:0] wb_GPR_wdata_not_lw,
    input  logic [DATA_WIDTH-1:0] wb_dmem_rdata,
    input  logic [ADDR_WIDTH-1:0] id_raddr1,
    input  logic [ADDR_WIDTH-1:0] id_raddr2,
    output logic [DATA_WIDTH-1:0] id_rdata1,
    output logic [DATA_WIDTH-1:0] id_rdata2,
    input  logic [ADDR_WIDTH-1:0] dbg_raddr,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  wb_commit_valid,
    output logic [ADDR_WIDTH-1:0] wb_commit_addr,
    output logic [DATA_WIDTH-1:0] wb_commit_data,
    output logic [31:0]           wb_commit_count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int SP_IDX = 29;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic                  commit_valid_q, commit_valid_d;
    logic [ADDR_WIDTH-1:0] commit_addr_q, commit_addr_d;
    logic [DATA_WIDTH-1:0] commit_data_q, commit_data_d;
    logic [31:0]           commit_count_q, commit_count_d;

    logic [DATA_WIDTH-1:0] wdata;
    logic                  commit;

    assign wdata  = (wb_GPR_wdata_select == 2'b00) ? wb_dmem_rdata : wb_GPR_wdata_not_lw;
    assign commit = wb_GPR_we && (wb_GPR_waddr != '0) && !reset;

    always_comb begin
        commit_valid_d = commit;
        commit_addr_d  = commit_addr_q;
        commit_data_d  = commit_data_q;
        commit_count_d = commit_count_q;
        if (commit) begin
            commit_addr_d  = wb_GPR_waddr;
            commit_data_d  = wdata;
            commit_count_d = commit_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
            end
            commit_valid_q <= 1'b0;
            commit_addr_q  <= '0;
            commit_data_q  <= '0;
            commit_count_q <= '0;
        end else begin
            if (commit) begin
                regs_q[wb_GPR_waddr] <= wdata;
            end
            commit_valid_q <= commit_valid_d;
            commit_addr_q  <= commit_addr_d;
            commit_data_q  <= commit_data_d;
            commit_count_q <= commit_count_d;
        end
    end

    // Register 0 is forced to zero on every port, independent of stored contents.
    function automatic logic [DATA_WIDTH-1:0] stored(input logic [ADDR_WIDTH-1:0] a);
        return (a == '0) ? '0 : regs_q[a];
    endfunction

`ifdef GPR_WB_BYPASS_EN
    assign id_rdata1 = (commit && (id_raddr1 == wb_GPR_waddr)) ? wdata : stored(id_raddr1);
    assign id_rdata2 = (commit && (id_raddr2 == wb_GPR_waddr)) ? wdata : stored(id_raddr2);
`else
    assign id_rdata1 = stored(id_raddr1);
    assign id_rdata2 = stored(id_raddr2);
`endif

    assign dbg_rdata       = stored(dbg_raddr);
    assign wb_commit_valid = commit_valid_q;
    assign wb_commit_addr  = commit_addr_q;
    assign wb_commit_data  = commit_data_q;
    assign wb_commit_count = commit_count_q;

endmodule

// File: tb/tb_gpr_file.sv
// tb/tb_gpr_file.sv - directed vector bench for gpr_file
module tb_gpr_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  waddr;
    logic [1:0]  sel;
    logic [31:0] not_lw;
    logic [31:0] dmem;
    logic [4:0]  raddr1, raddr2, draddr;
    logic [31:0] rdata1, rdata2, drdata;
    logic        c_valid;
    logic [4:0]  c_addr;
    logic [31:0] c_data, c_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gpr_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .SP_INIT(32'h0000_3FFC)) dut (
        .clk                (clk),
        .reset              (reset),
        .wb_GPR_we          (we),
        .wb_GPR_waddr       (waddr),
        .wb_GPR_wdata_select(sel),
        .wb_GPR_wdata_not_lw(not_lw),
        .wb_dmem_rdata      (dmem),
        .id_raddr1          (raddr1),
        .id_raddr2          (raddr2),
        .id_rdata1          (rdata1),
        .id_rdata2          (rdata2),
        .dbg_raddr          (draddr),
        .dbg_rdata          (drdata),
        .wb_commit_valid    (c_valid),
        .wb_commit_addr     (c_addr),
        .wb_commit_data     (c_data),
        .wb_commit_count    (c_count)
    );

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [1:0]  sel;
        logic [31:0] not_lw;
        logic [31:0] dmem;
        logic [4:0]  r1, r2, dr;
        logic [31:0] exp_r1, exp_r2, exp_dr;
        logic        exp_valid;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        logic [31:0] exp_count;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 5'd5,  2'b01, 32'h1234_5678, 32'h0000_0000, 5'd5,  5'd29, 5'd5,
                    32'h1234_5678, 32'h0000_3FFC, 32'h1234_5678, 1'b1, 5'd5,  32'h1234_5678, 32'd1};
        vecs[1] = '{1'b1, 5'd8,  2'b00, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 5'd8,  5'd5,  5'd8,
                    32'hDEAD_BEEF, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1, 5'd8,  32'hDEAD_BEEF, 32'd2};
        vecs[2] = '{1'b1, 5'd0,  2'b01, 32'hAAAA_AAAA, 32'h0000_0000, 5'd0,  5'd0,  5'd0,
                    32'h0,         32'h0,         32'h0,         1'b0, 5'd8,  32'hDEAD_BEEF, 32'd2};
        vecs[3] = '{1'b0, 5'd9,  2'b10, 32'h0000_0005, 32'h0000_0000, 5'd9,  5'd8,  5'd9,
                    32'h0,         32'hDEAD_BEEF, 32'h0,         1'b0, 5'd8,  32'hDEAD_BEEF, 32'd2};
        vecs[4] = '{1'b1, 5'd31, 2'b11, 32'hCAFE_F00D, 32'h1111_1111, 5'd31, 5'd31, 5'd31,
                    32'hCAFE_F00D, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1, 5'd31, 32'hCAFE_F00D, 32'd3};
        vecs[5] = '{1'b1, 5'd3,  2'b10, 32'h0000_0011, 32'h2222_2222, 5'd3,  5'd8,  5'd3,
                    32'h0000_0011, 32'hDEAD_BEEF, 32'h0000_0011, 1'b1, 5'd3,  32'h0000_0011, 32'd4};
        vecs[6] = '{1'b1, 5'd29, 2'b00, 32'h0000_0007, 32'h0000_1000, 5'd29, 5'd3,  5'd29,
                    32'h0000_1000, 32'h0000_0011, 32'h0000_1000, 1'b1, 5'd29, 32'h0000_1000, 32'd5};

        reset = 1'b1; we = 1'b0; waddr = '0; sel = '0; not_lw = '0; dmem = '0;
        raddr1 = '0; raddr2 = '0; draddr = '0;
        step();
        step();
        reset = 1'b0;
        #1;

        for (int i = 0; i < 32; i++) begin
            draddr = 5'(i);
            #1;
            check($sformatf("reset_reg%0d", i), drdata, (i == 29) ? 32'h0000_3FFC : 32'h0);
        end
        check("reset_count", c_count, 32'd0);
        check("reset_valid", {31'd0, c_valid}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            we = vecs[i].we; waddr = vecs[i].waddr; sel = vecs[i].sel;
            not_lw = vecs[i].not_lw; dmem = vecs[i].dmem;
            raddr1 = vecs[i].r1; raddr2 = vecs[i].r2; draddr = vecs[i].dr;
            step();
            we = 1'b0;
            #1;
            check($sformatf("v%0d_rdata1", i), rdata1, vecs[i].exp_r1);
            check($sformatf("v%0d_rdata2", i), rdata2, vecs[i].exp_r2);
            check($sformatf("v%0d_dbg", i), drdata, vecs[i].exp_dr);
            check($sformatf("v%0d_valid", i), {31'd0, c_valid}, {31'd0, vecs[i].exp_valid});
            check($sformatf("v%0d_addr", i), {27'd0, c_addr}, {27'd0, vecs[i].exp_addr});
            check($sformatf("v%0d_data", i), c_data, vecs[i].exp_data);
            check($sformatf("v%0d_count", i), c_count, vecs[i].exp_count);
        end

        // Same-cycle read of a register being written (old value 0x11).
        we = 1'b1; waddr = 5'd3; sel = 2'b01; not_lw = 32'h55; dmem = 32'h0;
        raddr1 = 5'd3; raddr2 = 5'd3; draddr = 5'd3;
        #1;
`ifdef GPR_WB_BYPASS_EN
        check("same_cycle_r1", rdata1, 32'h55);
        check("same_cycle_r2", rdata2, 32'h55);
`else
        check("same_cycle_r1", rdata1, 32'h11);
        check("same_cycle_r2", rdata2, 32'h11);
`endif
        check("same_cycle_dbg", drdata, 32'h11);
        step();
        we = 1'b0;
        #1;
        check("next_cycle_r1", rdata1, 32'h55);
        check("next_cycle_r2", rdata2, 32'h55);
        check("next_cycle_dbg", drdata, 32'h55);
        check("next_cycle_valid", {31'd0, c_valid}, 32'd1);
        check("next_cycle_count", c_count, 32'd6);
        step();
        check("idle_valid", {31'd0, c_valid}, 32'd0);
        check("idle_count", c_count, 32'd6);

        // Reset takes priority over a simultaneous write.
        reset = 1'b1; we = 1'b1; waddr = 5'd7; sel = 2'b01; not_lw = 32'h99;
        step();
        reset = 1'b0; we = 1'b0;
        draddr = 5'd7; raddr1 = 5'd7; raddr2 = 5'd29;
        #1;
        check("rst_wr_reg7", drdata, 32'h0);
        check("rst_wr_r1", rdata1, 32'h0);
        check("rst_wr_sp", rdata2, 32'h0000_3FFC);
        check("rst_wr_valid", {31'd0, c_valid}, 32'd0);
        check("rst_wr_addr", {27'd0, c_addr}, 32'd0);
        check("rst_wr_data", c_data, 32'h0);
        check("rst_wr_count", c_count, 32'd0);
        draddr = 5'd3;
        #1;
        check("rst_wr_reg3", drdata, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpr_file.md
Name: gpr_file

Overview:
- General-purpose register file that consumes the write-back bundle produced at the end of the MEM stage.
- Resolves the final write data by choosing between load data and pre-muxed non-load data.
- Commits the write on the clock edge.
- Serves two ID-stage read ports plus one debug read port.
- The write side is the far end of the MEM/WB interface; the read side feeds ID operand fetch and the pipeline controller.

Parameters:
- DATA_WIDTH, 32, register width.
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH.
- SP_INIT, 32'h0000_0000, reset value loaded into register 29; all other registers reset to 0.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- wb_GPR_we  input  1  write enable from MEM/WB stage.
- wb_GPR_waddr  input  ADDR_WIDTH  destination register index.
- wb_GPR_wdata_select  input  2  write source: 2'b00 = load data, others = non-load data.
- wb_GPR_wdata_not_lw  input  DATA_WIDTH  pre-selected ALU / link data.
- wb_dmem_rdata  input  DATA_WIDTH  DMEM read data, valid in WB.
- id_raddr1  input  ADDR_WIDTH  read port 1 index (rs).
- id_raddr2  input  ADDR_WIDTH  read port 2 index (rt).
- id_rdata1  output  DATA_WIDTH  read port 1 data.
- id_rdata2  output  DATA_WIDTH  read port 2 data.
- dbg_raddr  input  ADDR_WIDTH  debug read index.
- dbg_rdata  output  DATA_WIDTH  debug read data.
- wb_commit_valid  output  1  registered pulse: a write committed last edge.
- wb_commit_addr  output  ADDR_WIDTH  registered index of last commit.
- wb_commit_data  output  DATA_WIDTH  registered data of last commit.
- wb_commit_count  output  32  count of committed writes since reset.

Behaviour:
- Reset is synchronous and active-high.
  - At posedge clk with reset = 1: all registers = 0 except reg 29 = SP_INIT.
  - wb_commit_valid = 0, wb_commit_addr = 0, wb_commit_data = 0, wb_commit_count = 0.
  - Reset has priority over any simultaneous write; the write is dropped.
- Write data: wdata = (wb_GPR_wdata_select == 2'b00) ? wb_dmem_rdata : wb_GPR_wdata_not_lw.
- Commit condition: commit = wb_GPR_we && (wb_GPR_waddr != 0) && !reset. A write to register 0 is discarded.
- On commit, at posedge:
  - regs[waddr] <= wdata.
  - wb_commit_valid <= 1, wb_commit_addr <= waddr, wb_commit_data <= wdata.
  - wb_commit_count <= count + 1; wraps 0xFFFFFFFF -> 0.
- No commit (not in reset): wb_commit_valid <= 0; addr, data and count hold.
- Reads are combinational. Register 0 always reads 0 on all three ports, regardless of any write attempt.
- Latency: a commit is visible on a read port in the cycle after the edge; same-cycle behaviour is set by the optional feature.
- Both read ports may address the same register; both return identical data.
- dbg_rdata never bypasses; it always shows stored state.

Optional Feature:
- Macro: GPR_WB_BYPASS_EN.
- Defined: write-through bypass on id_rdata1/2.
  - If the commit condition holds and raddr == wb_GPR_waddr, the port returns wdata combinationally in the same cycle.
  - The pipeline controller needs no WB-to-ID stall.
- Undefined: read ports return stored values only.
  - A same-cycle read of the register being written returns the old value.
  - The controller must stall ID one cycle.

Test Plan:
- Reset with SP_INIT = 32'h0000_3FFC, then read all 32 registers on dbg -> reg29 = 0x3FFC, all others 0, commit_count = 0.
- we = 1, waddr = 5, sel = 01, not_lw = 0x1234_5678 -> next cycle id_rdata1 (raddr1 = 5) = 0x12345678, commit_valid = 1, commit_addr = 5, count = 1.
- we = 1, waddr = 8, sel = 00, dmem_rdata = 0xDEAD_BEEF, not_lw = 0xFFFF_FFFF -> reg8 = 0xDEADBEEF.
- we = 1, waddr = 0, not_lw = 0xAAAA_AAAA -> reg0 reads 0, commit_valid = 0, count unchanged.
- Same-cycle write reg 3 = 0x55 while raddr1 = raddr2 = 3, old value 0x11:
  - Bypass defined -> both ports 0x55.
  - Bypass undefined -> both ports 0x11 this cycle, 0x55 next cycle.
- reset = 1 asserted together with we = 1, waddr = 7, data 0x99 -> reg7 = 0, commit_valid = 0, count = 0.
